// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
//
// Control sequencer for the stopwatch datapath. Synchronises and debounces
// the raw start/stop, lap and clear buttons, runs the stopwatch state
// machine and produces the gated seconds tick, the counter clear pulse and
// the lap display-freeze controls.
//
// Ports:
//   clock_100Mhz  in   system clock, rising edge
//   reset         in   asynchronous, active-low reset
//   btn_start     in   raw start/stop button (async, active-high)
//   btn_lap       in   raw lap button (async, active-high)
//   btn_clear     in   raw clear button (async, active-high)
//   sec_tick      out  one-cycle count-enable pulse to the seconds counter
//   count_clear   out  one-cycle clear pulse to all time counters
//   run           out  high in RUNNING or LAP
//   lap_freeze    out  high in LAP (display shows the latched snapshot)
//   lap_capture   out  one-cycle pulse on entry to LAP
//   state         out  IDLE=00, RUNNING=01, PAUSED=10, LAP=11
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int TICK_DIV        = 100000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clock_100Mhz,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clear,
    output logic       sec_tick,
    output logic       count_clear,
    output logic       run,
    output logic       lap_freeze,
    output logic       lap_capture,
    output logic [1:0] state
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] DB_LIMIT  = CW'(DEBOUNCE_CYCLES);

    // Button lane indices inside the 3-bit vectors below.
    localparam int B_START = 0;
    localparam int B_LAP   = 1;
    localparam int B_CLEAR = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_LAP     = 2'b11
    } state_t;

    logic [2:0]    sync1_q, sync1_d;
    logic [2:0]    sync2_q, sync2_d;
    logic [2:0]    db_lvl_q, db_lvl_d;
    logic [CW-1:0] db_cnt_q [3];
    logic [CW-1:0] db_cnt_d [3];
    logic [2:0]    press_q, press_d;
    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          clear_q, clear_d;
    logic          capture_q, capture_d;
    logic          run_now, run_next;

    // Synchroniser and debounce. The counter measures how long the
    // synchronised level has disagreed with the accepted level; any agreement
    // restarts it, so only an uninterrupted run of DEBOUNCE_CYCLES counts.
    always_comb begin
        sync1_d  = {btn_clear, btn_lap, btn_start};
        sync2_d  = sync1_q;
        db_lvl_d = db_lvl_q;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_lvl_q[i]) begin
                if (db_cnt_q[i] + CW'(1) == DB_LIMIT) begin
                    db_lvl_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CW'(1);
                end
            end
        end
        // Press events fire on rising debounced levels only.
        press_d = db_lvl_d & ~db_lvl_q;
    end

    // State machine: only the highest-priority event of a cycle is looked
    // at (clear > start > lap); an ignored winner still swallows the others.
    always_comb begin
        state_d   = state_q;
        clear_d   = 1'b0;
        capture_d = 1'b0;
        if (press_q[B_CLEAR]) begin
            case (state_q)
                ST_IDLE:   clear_d = 1'b1;
                ST_PAUSED: begin
                    state_d = ST_IDLE;
                    clear_d = 1'b1;
                end
                default: ;
            endcase
        end else if (press_q[B_START]) begin
            case (state_q)
                ST_IDLE, ST_PAUSED:  state_d = ST_RUNNING;
                ST_RUNNING, ST_LAP:  state_d = ST_PAUSED;
                default: ;
            endcase
        end else if (press_q[B_LAP]) begin
            case (state_q)
                ST_RUNNING: begin
                    state_d   = ST_LAP;
                    capture_d = 1'b1;
                end
                ST_LAP:  state_d = ST_RUNNING;
                default: ;
            endcase
        end
    end

    // Prescaler advances only on edges that start and end in a running
    // state: the resume edge and the pause edge both hold it, which keeps
    // the partial second intact and suppresses a tick due on the leave edge.
    always_comb begin
        run_now  = (state_q == ST_RUNNING) || (state_q == ST_LAP);
        run_next = (state_d == ST_RUNNING) || (state_d == ST_LAP);
        presc_d  = presc_q;
        tick_d   = 1'b0;
        if (state_d == ST_IDLE) begin
            presc_d = '0;
        end else if (run_now && run_next) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_lvl_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
            press_q   <= '0;
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            clear_q   <= 1'b0;
            capture_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_lvl_q  <= db_lvl_d;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            press_q   <= press_d;
            state_q   <= state_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            clear_q   <= clear_d;
            capture_q <= capture_d;
        end
    end

    assign sec_tick    = tick_q;
    assign count_clear = clear_q;
    assign lap_capture = capture_q;
    assign run         = (state_q == ST_RUNNING) || (state_q == ST_LAP);
    assign lap_freeze  = (state_q == ST_LAP);
    assign state       = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Self-checking bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=10.
// A cycle-level behavioural model (button delay line, run-length debounce,
// event-priority state table and a running-edge count for ticks) is
// compared against every output on every cycle. On top of that a table of
// press vectors and hand-written sequences check the fixed latencies and
// pulse counts directly.
// ---------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    localparam int D      = 4;
    localparam int TD     = 10;
    localparam int HOLD   = 6;
    localparam int SETTLE = 12;
    // Press latency: 2 sync edges + D debounce edges + 1 event edge.
    localparam int PRESS_LAT = D + 3;

    localparam logic [2:0] B_NONE  = 3'b000;
    localparam logic [2:0] B_START = 3'b001;
    localparam logic [2:0] B_LAP   = 3'b010;
    localparam logic [2:0] B_CLEAR = 3'b100;

    localparam int ST_IDLE    = 0;
    localparam int ST_RUNNING = 1;
    localparam int ST_PAUSED  = 2;
    localparam int ST_LAP     = 3;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_lap = 1'b0;
    logic       btn_clear = 1'b0;
    logic       sec_tick;
    logic       count_clear;
    logic       run;
    logic       lap_freeze;
    logic       lap_capture;
    logic [1:0] state;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .TICK_DIV       (TD),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clock_100Mhz(clk),
        .reset       (rst_n),
        .btn_start   (btn_start),
        .btn_lap     (btn_lap),
        .btn_clear   (btn_clear),
        .sec_tick    (sec_tick),
        .count_clear (count_clear),
        .run         (run),
        .lap_freeze  (lap_freeze),
        .lap_capture (lap_capture),
        .state       (state)
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;
    int tick_seen = 0;
    int cc_seen = 0;
    int cap_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit [2:0] m_p1, m_p2;     // raw buttons seen one / two edges ago
    bit [2:0] m_lvl;          // accepted (debounced) levels
    int       m_diff [3];     // length of current disagreement run
    bit [2:0] m_ev;           // press events visible this cycle
    int       m_state;
    int       m_run_edges;    // running edges since last entering IDLE
    bit       m_tick, m_cc, m_cap;

    function automatic bit runs(input int s);
        return (s == ST_RUNNING) || (s == ST_LAP);
    endfunction

    task automatic model_reset();
        m_p1 = '0; m_p2 = '0; m_lvl = '0; m_ev = '0;
        for (int b = 0; b < 3; b++) m_diff[b] = 0;
        m_state = ST_IDLE; m_run_edges = 0;
        m_tick = 0; m_cc = 0; m_cap = 0;
    endtask

    task automatic model_edge(input logic [2:0] raw);
        int       nxt;
        bit       new_tick, new_cc, new_cap;
        bit [2:0] new_ev;
        nxt = m_state; new_tick = 0; new_cc = 0; new_cap = 0; new_ev = '0;
        if (m_ev[2]) begin
            if (m_state == ST_IDLE) new_cc = 1;
            else if (m_state == ST_PAUSED) begin nxt = ST_IDLE; new_cc = 1; end
        end else if (m_ev[0]) begin
            nxt = (m_state == ST_IDLE || m_state == ST_PAUSED) ? ST_RUNNING : ST_PAUSED;
        end else if (m_ev[1]) begin
            if (m_state == ST_RUNNING) begin nxt = ST_LAP; new_cap = 1; end
            else if (m_state == ST_LAP) nxt = ST_RUNNING;
        end
        if (nxt == ST_IDLE) begin
            m_run_edges = 0;
        end else if (runs(m_state) && runs(nxt)) begin
            m_run_edges++;
            new_tick = (m_run_edges % TD) == 0;
        end
        for (int b = 0; b < 3; b++) begin
            if (m_p2[b] != m_lvl[b]) begin
                m_diff[b]++;
                if (m_diff[b] == D) begin
                    m_lvl[b]  = m_p2[b];
                    m_diff[b] = 0;
                    new_ev[b] = m_lvl[b];
                end
            end else begin
                m_diff[b] = 0;
            end
        end
        m_p2 = m_p1; m_p1 = raw; m_ev = new_ev;
        m_state = nxt; m_tick = new_tick; m_cc = new_cc; m_cap = new_cap;
    endtask

    task automatic compare_model();
        check("sec_tick", sec_tick, m_tick);
        check("count_clear", count_clear, m_cc);
        check("lap_capture", lap_capture, m_cap);
        check("state", state, m_state);
        check("run", run, runs(m_state));
        check("lap_freeze", lap_freeze, m_state == ST_LAP);
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_btns(input logic [2:0] mask);
        {btn_clear, btn_lap, btn_start} = mask;
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge({btn_clear, btn_lap, btn_start});
        #1;
        compare_model();
        if (sec_tick) tick_seen++;
        if (count_clear) cc_seen++;
        if (lap_capture) cap_seen++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();
    endtask

    // Press, release after HOLD edges, return edges until state changed (bounded).
    task automatic press_measure(input logic [2:0] mask, output int n);
        logic [1:0] s0;
        s0 = state;
        set_btns(mask);
        n = 0;
        while (n < 20) begin
            step();
            n++;
            if (n == HOLD) set_btns(B_NONE);
            if (state != s0) break;
        end
        set_btns(B_NONE);
    endtask

    task automatic wait_tick(input int bound, output int n);
        n = 0;
        while (n < bound) begin
            step();
            n++;
            if (sec_tick) break;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0] btns;
        logic [1:0] exp_state;
        int         exp_cc;
        int         exp_cap;
    } vec_t;

    vec_t vecs [19];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t0;
        int c0;
        int p0;

        vecs[0]  = '{B_CLEAR,           2'b00, 1, 0};
        vecs[1]  = '{B_LAP,             2'b00, 0, 0};
        vecs[2]  = '{B_START,           2'b01, 0, 0};
        vecs[3]  = '{B_CLEAR,           2'b01, 0, 0};
        vecs[4]  = '{B_LAP,             2'b11, 0, 1};
        vecs[5]  = '{B_CLEAR,           2'b11, 0, 0};
        vecs[6]  = '{B_LAP,             2'b01, 0, 0};
        vecs[7]  = '{B_LAP,             2'b11, 0, 1};
        vecs[8]  = '{B_START,           2'b10, 0, 0};
        vecs[9]  = '{B_LAP,             2'b10, 0, 0};
        vecs[10] = '{B_START,           2'b01, 0, 0};
        vecs[11] = '{B_START,           2'b10, 0, 0};
        vecs[12] = '{B_START | B_CLEAR, 2'b00, 1, 0};
        vecs[13] = '{B_START,           2'b01, 0, 0};
        vecs[14] = '{B_START | B_LAP,   2'b10, 0, 0};
        vecs[15] = '{B_CLEAR | B_LAP,   2'b00, 1, 0};
        vecs[16] = '{B_START,           2'b01, 0, 0};
        vecs[17] = '{B_CLEAR | B_LAP,   2'b01, 0, 0};
        vecs[18] = '{B_START,           2'b10, 0, 0};

        // Reset, then idle.
        model_reset();
        repeat (5) step();
        rst_n = 1'b1;
        t0 = tick_seen;
        repeat (50) step();
        check("idle_ticks", tick_seen - t0, 0);
        check("idle_state", state, 2'b00);
        check("idle_run", run, 1'b0);

        // Glitches on start produce nothing; a clean hold starts the watch.
        set_btns(B_START); repeat (2) step();
        set_btns(B_NONE);  repeat (2) step();
        set_btns(B_START); repeat (2) step();
        set_btns(B_NONE);  repeat (10) step();
        check("glitch_state", state, 2'b00);
        press_measure(B_START, n);
        check("start_latency", n, PRESS_LAT);
        check("start_state", state, 2'b01);
        check("start_run", run, 1'b1);
        wait_tick(30, n);
        check("first_tick_gap", n, TD);
        wait_tick(30, n);
        check("second_tick_gap", n, TD);

        // Pause with prescaler at 6, idle paused, resume: tick after 4.
        press_measure(B_START, n);
        check("pause_latency", n, PRESS_LAT);
        check("pause_state", state, 2'b10);
        t0 = tick_seen;
        repeat (30) step();
        check("paused_ticks", tick_seen - t0, 0);
        press_measure(B_START, n);
        check("resume_state", state, 2'b01);
        wait_tick(30, n);
        check("resume_tick_gap", n, TD - 6);

        // Lap in and out.
        c0 = cap_seen; t0 = tick_seen;
        press_measure(B_LAP, n);
        check("lap_latency", n, PRESS_LAT);
        check("lap_state", state, 2'b11);
        check("lap_freeze_on", lap_freeze, 1'b1);
        repeat (SETTLE + 8) step();
        check("lap_capture_count", cap_seen - c0, 1);
        check("lap_ticks_continue", (tick_seen - t0) >= 2, 1'b1);
        c0 = cap_seen;
        press_measure(B_LAP, n);
        check("unlap_state", state, 2'b01);
        check("unlap_freeze_off", lap_freeze, 1'b0);
        repeat (SETTLE) step();
        check("unlap_capture_count", cap_seen - c0, 0);

        // Table of presses starting from IDLE.
        do_reset();
        for (int i = 0; i < 19; i++) begin
            c0 = cc_seen; p0 = cap_seen;
            set_btns(vecs[i].btns);
            repeat (HOLD) step();
            set_btns(B_NONE);
            repeat (SETTLE) step();
            check($sformatf("vec%0d_state", i), state, vecs[i].exp_state);
            check($sformatf("vec%0d_run", i), run, vecs[i].exp_state[0]);
            check($sformatf("vec%0d_freeze", i), lap_freeze, vecs[i].exp_state == 2'b11);
            check($sformatf("vec%0d_clear_pulses", i), cc_seen - c0, vecs[i].exp_cc);
            check($sformatf("vec%0d_capture_pulses", i), cap_seen - p0, vecs[i].exp_cap);
        end

        // Reset during LAP aborts at once; start held through reset fires once.
        press_measure(B_START, n);
        repeat (SETTLE) step();
        press_measure(B_LAP, n);
        repeat (3) step();
        check("pre_reset_state", state, 2'b11);
        #3;
        rst_n = 1'b0;
        btn_start = 1'b1;
        #1;
        model_reset();
        check("async_rst_state", state, 2'b00);
        check("async_rst_run", run, 1'b0);
        check("async_rst_freeze", lap_freeze, 1'b0);
        check("async_rst_tick", sec_tick, 1'b0);
        check("async_rst_clear", count_clear, 1'b0);
        check("async_rst_capture", lap_capture, 1'b0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (12) step();
        check("held_through_reset_state", state, 2'b01);
        set_btns(B_NONE);
        repeat (SETTLE) step();
        check("release_no_event_state", state, 2'b01);

        // Random presses, glitches and occasional resets against the model.
        for (int i = 0; i < 150; i++) begin
            set_btns(3'($urandom_range(0, 7)));
            repeat ($urandom_range(1, 8)) step();
            set_btns(B_NONE);
            repeat ($urandom_range(0, 12)) step();
            if ($urandom_range(0, 49) == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
